sync_to_count: RTL and testbench

- Receive-side counterpart of the frame counter.
- Takes incoming active-low HSync/VSync pulses and regenerates the H/V pixel counts, phase-aligned to the sync edges.
- Supervises lock with a small state machine and reports when the incoming timing matches HMAX x VMAX.
- Sits between an external or looped-back VGA sync source and the downstream drawing logic (paddles, ball).

---
 rtl/sync_to_count_pkg.sv | 24 ++
 rtl/sync_to_count_edge_detect.sv | 27 ++
 rtl/sync_to_count.sv | 153 +++++++++++++++
 tb/tb_sync_to_count.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_to_count_pkg.sv
// rtl/sync_to_count_pkg.sv - shared 640x480 VGA timing constants and lock-state type
package sync_to_count_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int DEF_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_ACQUIRE  = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_to_count_edge_detect.sv
// rtl/sync_to_count_edge_detect.sv - two-flop sync sampler with falling-edge event
module sync_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sync,
    output logic o_Sync,
    output logic o_Fall
);

    logic r_1_q;
    logic r_2_q;

    // Reset to idle-high so a sync already low at release still yields a fall event.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_1_q <= 1'b1;
            r_2_q <= 1'b1;
        end else begin
            r_1_q <= i_Sync;
            r_2_q <= r_1_q;
        end
    end

    assign o_Sync = r_2_q;
    assign o_Fall = r_2_q & ~r_1_q;

endmodule

// File: rtl/sync_to_count.sv
// rtl/sync_to_count.sv - regenerate H/V counts from incoming syncs and supervise lock
module sync_to_count
    import sync_to_count_pkg::*;
#(
    parameter int HMAX        = H_TOTAL,
    parameter int VMAX        = V_TOTAL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_HSync,
    input  logic                    i_VSync,
    output logic                    o_HSync,
    output logic                    o_VSync,
    output logic [$clog2(HMAX)-1:0] o_H_count,
    output logic [$clog2(VMAX)-1:0] o_V_count,
    output logic                    o_Locked,
    output logic                    o_Frame_start,
    output logic                    o_Frame_end
);

    localparam int HW = $clog2(HMAX);
    localparam int VW = $clog2(VMAX);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(HMAX - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(VMAX - 1);
    localparam logic [GW-1:0] GOOD_FULL = GW'(LOCK_FRAMES);

    logic h_fall;
    logic v_fall;

    sync_edge_detect u_hs_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sync  (i_HSync),
        .o_Sync  (o_HSync),
        .o_Fall  (h_fall)
    );

    sync_edge_detect u_vs_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sync  (i_VSync),
        .o_Sync  (o_VSync),
        .o_Fall  (v_fall)
    );

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_end;
    logic          frame_end;

    assign h_end     = (h_q == H_LAST);
    assign frame_end = h_end && (v_q == V_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // VSync fall beats HSync fall, which beats free-running.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (v_fall) begin
            h_d = '0;
            v_d = '0;
        end else if (h_fall || h_end) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    lock_state_e   state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [GW-1:0] good_inc;
    logic          timing_err;

    // Sync edges must land exactly where the free-running count expects them.
    always_comb begin
        timing_err = 1'b0;
        if (state_q != LK_UNLOCKED) begin
            timing_err = (h_fall && !h_end)
                      || (h_end && !h_fall)
                      || (v_fall && !frame_end)
                      || (frame_end && !v_fall);
        end
    end

    assign good_inc = good_q + GW'(1);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= LK_UNLOCKED;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            LK_UNLOCKED: begin
                if (v_fall) begin
                    state_d = LK_ACQUIRE;
                    good_d  = '0;
                end
            end
            LK_ACQUIRE: begin
                if (timing_err) begin
                    state_d = LK_UNLOCKED;
                    good_d  = '0;
                end else if (v_fall) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_FULL) begin
                        state_d = LK_LOCKED;
                    end
                end
            end
            LK_LOCKED: begin
                if (timing_err) begin
                    state_d = LK_UNLOCKED;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = LK_UNLOCKED;
                good_d  = '0;
            end
        endcase
    end

    always_comb begin
        o_Locked      = (state_q == LK_LOCKED);
        o_Frame_start = o_Locked && (h_q == '0) && (v_q == '0);
        o_Frame_end   = o_Locked && frame_end;
    end

    assign o_H_count = h_q;
    assign o_V_count = v_q;

endmodule

// File: tb/tb_sync_to_count.sv
// tb/tb_sync_to_count.sv - self-checking bench for sync_to_count on reduced geometries
module tb_sync_to_count;

    localparam int HM = 20;
    localparam int VM = 8;
    localparam int LF = 2;
    localparam int N  = HM * VM;
    localparam int HS_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       i_Reset;
    logic       i_HSync;
    logic       i_VSync;
    logic       o_HSync, o_VSync;
    logic [4:0] o_H_count;
    logic [2:0] o_V_count;
    logic       o_Locked, o_Frame_start, o_Frame_end;

    logic       s_HSync, s_VSync;
    logic [3:0] s_H_count;
    logic [2:0] s_V_count;
    logic       s_Locked, s_Frame_start, s_Frame_end;

    sync_to_count #(.HMAX(HM), .VMAX(VM), .LOCK_FRAMES(LF)) dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_HSync       (i_HSync),
        .i_VSync       (i_VSync),
        .o_HSync       (o_HSync),
        .o_VSync       (o_VSync),
        .o_H_count     (o_H_count),
        .o_V_count     (o_V_count),
        .o_Locked      (o_Locked),
        .o_Frame_start (o_Frame_start),
        .o_Frame_end   (o_Frame_end)
    );

    sync_to_count #(.HMAX(10), .VMAX(6), .LOCK_FRAMES(1)) dut_small (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_HSync       (1'b1),
        .i_VSync       (1'b1),
        .o_HSync       (s_HSync),
        .o_VSync       (s_VSync),
        .o_H_count     (s_H_count),
        .o_V_count     (s_V_count),
        .o_Locked      (s_Locked),
        .o_Frame_start (s_Frame_start),
        .o_Frame_end   (s_Frame_end)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: linear pixel position within the frame plus a lock mode
    int pos, mode, good, cyc, spos;
    bit s1h, s2h, s1v, s2v;
    bit started = 0;

    always @(posedge clk) begin
        bit hf, vf, err;
        int col;
        if (i_Reset) begin
            pos = 0; mode = 0; good = 0; cyc = 0; spos = 0;
            s1h = 1; s2h = 1; s1v = 1; s2v = 1;
            started = 1;
        end else begin
            hf  = s2h && !s1h;
            vf  = s2v && !s1v;
            col = pos % HM;
            err = (hf && col != HM - 1) || (col == HM - 1 && !hf)
               || (vf && pos != N - 1) || (pos == N - 1 && !vf);
            if (mode != 0 && err) begin
                mode = 0; good = 0;
            end else if (vf) begin
                if (mode == 0) begin
                    mode = 1; good = 0;
                end else if (mode == 1) begin
                    good++;
                    if (good == LF) mode = 2;
                end
            end
            if (vf)      pos = 0;
            else if (hf) pos = ((pos / HM + 1) % VM) * HM;
            else         pos = (pos + 1) % N;
            s2h = s1h; s1h = i_HSync;
            s2v = s1v; s1v = i_VSync;
            cyc++;
            spos = (spos + 1) % 60;
        end
    end

    int lock_rise_cyc = -1;
    int fs_cyc [2] = '{-1, -1};
    int fs_n = 0;
    int fe0 = -1;
    int fall_h = -1, fall_v = -1;
    bit prev_lk = 0;
    int prev_h = 0, prev_v = 0;

    always @(negedge clk) begin
        logic [12:0] exp_m, act_m;
        logic [11:0] exp_s, act_s;
        if (started) begin
            exp_m = {s2h, s2v, 5'(pos % HM), 3'(pos / HM), (mode == 2),
                     (mode == 2) && (pos == 0), (mode == 2) && (pos == N - 1)};
            act_m = {o_HSync, o_VSync, o_H_count, o_V_count, o_Locked, o_Frame_start, o_Frame_end};
            checks++;
            if (act_m !== exp_m) begin
                errors++;
                $display("FAIL main_outputs cyc=%0d: got %b required %b", cyc, act_m, exp_m);
            end
            exp_s = {1'b1, 1'b1, 4'(spos % 10), 3'(spos / 10), 1'b0, 1'b0, 1'b0};
            act_s = {s_HSync, s_VSync, s_H_count, s_V_count, s_Locked, s_Frame_start, s_Frame_end};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL small_freerun cyc=%0d: got %b required %b", cyc, act_s, exp_s);
            end
            if (o_Locked && lock_rise_cyc < 0) lock_rise_cyc = cyc;
            if (o_Frame_start && fs_n < 2) begin fs_cyc[fs_n] = cyc; fs_n++; end
            if (o_Frame_end && fe0 < 0) fe0 = cyc;
            if (prev_lk && !o_Locked) begin fall_h = prev_h; fall_v = prev_v; end
            prev_lk = o_Locked;
            prev_h  = int'(o_H_count);
            prev_v  = int'(o_V_count);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    int  gen_h = 0, gen_v = 0;
    int  supp_line = -1;
    bit  early_v = 0;

    task automatic drive();
        i_HSync = (gen_v == supp_line) ? 1'b1 : !(gen_h < HS_W);
        i_VSync = !((gen_v < 2) || (early_v && gen_v >= 3 && gen_v < 5));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_h == HM - 1) begin
            gen_h = 0;
            gen_v = (gen_v == VM - 1) ? 0 : gen_v + 1;
        end else begin
            gen_h++;
        end
        drive();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input int h, input int v);
        int n = 0;
        while (!(gen_h == h && gen_v == v) && n < 2 * N) begin
            tick();
            n++;
        end
        if (!(gen_h == h && gen_v == v)) begin
            errors++;
            $display("FAIL run_until_timeout: got position %0d,%0d required %0d,%0d", gen_h, gen_v, h, v);
        end
    endtask

    initial begin
        i_Reset = 1'b1;
        i_HSync = 1'b1;
        i_VSync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_Reset = 1'b0;
        gen_h = 0;
        gen_v = 0;
        drive();
        @(negedge clk);
        chk("reset_h_count", int'(o_H_count), 0);
        chk("reset_locked",  int'(o_Locked), 0);
        chk("reset_hsync",   int'(o_HSync), 1);

        // Clean stream: first VSync fall enters ACQUIRE, two good frames follow
        run_ticks(3 * N + 20);
        chk("lock_rise_cycle", lock_rise_cyc, 322);
        chk("locked_after_acquire", int'(o_Locked), 1);
        chk("first_frame_start", fs_cyc[0], 322);
        chk("second_frame_start", fs_cyc[1], 482);
        chk("first_frame_end", fe0, 481);

        // Missing HSync on line 5: lock drops right after the last column of line 4
        run_until(0, 0);
        supp_line = 5;
        fall_h = -1;
        fall_v = -1;
        run_until(0, 6);
        supp_line = -1;
        chk("missing_hsync_fall_h", fall_h, 19);
        chk("missing_hsync_fall_v", fall_v, 4);
        run_ticks(4 * N);
        chk("relock_after_hsync", int'(o_Locked), 1);

        // Early VSync at (0,3)
        run_until(HM - 1, 2);
        early_v = 1;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("early_v_h_count", int'(o_H_count), 0);
        chk("early_v_v_count", int'(o_V_count), 0);
        chk("early_v_unlocked", int'(o_Locked), 0);
        run_until(0, 5);
        early_v = 0;
        run_ticks(4 * N);
        chk("relock_after_early_v", int'(o_Locked), 1);

        // One-cycle reset while locked at (10,3)
        run_until(12, 3);
        @(negedge clk);
        chk("pre_reset_h", int'(o_H_count), 10);
        chk("pre_reset_v", int'(o_V_count), 3);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_h", int'(o_H_count), 0);
        chk("mid_reset_v", int'(o_V_count), 0);
        chk("mid_reset_locked", int'(o_Locked), 0);
        chk("mid_reset_syncs", int'({o_HSync, o_VSync}), 3);
        run_ticks(4 * N);
        chk("relock_after_reset", int'(o_Locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
